// File: rtl/mem_pipe_pkg.sv
// Shared encodings and default-width entry type for the EX->MEM pipeline boundary.
package mem_pipe_pkg;

  localparam int PC_W_DEF       = 30;
  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int CTRL_W_DEF     = 2;
  localparam int EXP_W_DEF      = 3;

  localparam logic [1:0] CTRL_OP_NOP        = 2'd0;
  localparam logic [2:0] ISA_EXP_NO_EXP     = 3'h0;
  localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'h4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  typedef struct packed {
    logic [PC_W_DEF-1:0]       pc;
    logic                      en;
    logic                      br_flag;
    logic [CTRL_W_DEF-1:0]     ctrl_op;
    logic [REG_ADDR_W_DEF-1:0] dst_addr;
    logic                      gpr_we_;
    logic [EXP_W_DEF-1:0]      exp_code;
    logic [DATA_W_DEF-1:0]     out;
  } mem_entry_t;

  // A bubble is a dead slot: no GPR write (gpr_we_ is active-low) and no exception.
  function automatic mem_entry_t mem_bubble();
    mem_entry_t b;
    b          = '0;
    b.ctrl_op  = CTRL_OP_NOP;
    b.gpr_we_  = 1'b1;
    b.exp_code = ISA_EXP_NO_EXP;
    return b;
  endfunction

endpackage

// File: rtl/mem_pipe_buf_if.sv
// EX->MEM handshake bundle: upstream valid/ready with EX fields, downstream valid/ready with MEM fields.
interface mem_pipe_buf_if #(
  parameter int PC_W       = 30,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 2,
  parameter int EXP_W      = 3
);
  logic                  up_valid;
  logic                  up_ready;
  logic [PC_W-1:0]       ex_pc;
  logic                  ex_en;
  logic                  ex_br_flag;
  logic [CTRL_W-1:0]     ex_ctrl_op;
  logic [REG_ADDR_W-1:0] ex_dst_addr;
  logic                  ex_gpr_we_;
  logic [EXP_W-1:0]      ex_exp_code;
  logic [DATA_W-1:0]     ex_out;
  logic                  miss_align;
  logic                  flush;
  logic                  dn_valid;
  logic                  dn_ready;
  logic [PC_W-1:0]       mem_pc;
  logic                  mem_en;
  logic                  mem_br_flag;
  logic [CTRL_W-1:0]     mem_ctrl_op;
  logic [REG_ADDR_W-1:0] mem_dst_addr;
  logic                  mem_gpr_we_;
  logic [EXP_W-1:0]      mem_exp_code;
  logic [DATA_W-1:0]     mem_out;

  modport master (
    output up_valid, ex_pc, ex_en, ex_br_flag, ex_ctrl_op, ex_dst_addr, ex_gpr_we_,
           ex_exp_code, ex_out, miss_align, flush, dn_ready,
    input  up_ready, dn_valid, mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr,
           mem_gpr_we_, mem_exp_code, mem_out
  );

  modport slave (
    input  up_valid, ex_pc, ex_en, ex_br_flag, ex_ctrl_op, ex_dst_addr, ex_gpr_we_,
           ex_exp_code, ex_out, miss_align, flush, dn_ready,
    output up_ready, dn_valid, mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr,
           mem_gpr_we_, mem_exp_code, mem_out
  );
endinterface

// File: rtl/mem_pipe_entry_reg.sv
// One pipeline entry slot; clear forces the bubble value and wins over load.
module mem_pipe_entry_reg #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= CLEAR_VALUE;
    end else if (clear) begin
      q <= CLEAR_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_pipe_buf.sv
// EX->MEM boundary with a 2-entry skid buffer; ready/valid are registered so EX and MEM stall independently.
module mem_pipe_buf
  import mem_pipe_pkg::*;
#(
  parameter int PC_W       = 30,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 2,
  parameter int EXP_W      = 3
) (
  input logic           clk,
  input logic           reset,
  mem_pipe_buf_if.slave bus
);

  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic                  en;
    logic                  br_flag;
    logic [CTRL_W-1:0]     ctrl_op;
    logic [REG_ADDR_W-1:0] dst_addr;
    logic                  gpr_we_;
    logic [EXP_W-1:0]      exp_code;
    logic [DATA_W-1:0]     out;
  } entry_t;

  localparam int     ENTRY_W = $bits(entry_t);
  localparam entry_t BUBBLE  = '{pc: '0, en: 1'b0, br_flag: 1'b0,
                                 ctrl_op: CTRL_W'(CTRL_OP_NOP), dst_addr: '0, gpr_we_: 1'b1,
                                 exp_code: EXP_W'(ISA_EXP_NO_EXP), out: '0};

  state_t state, state_next;
  logic   up_ready_q, dn_valid_q;
  logic   accept, pop;
  entry_t capture, head_d, head_q, skid_q;
  logic   head_load, head_clear, skid_load, skid_clear;

  assign accept = bus.up_valid & up_ready_q;
  assign pop    = dn_valid_q & bus.dn_ready;

  // Handshake flags are flopped from the next state so neither ready nor valid is combinational.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_EMPTY;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
    end else begin
      state      <= state_next;
      up_ready_q <= (state_next != ST_FULL);
      dn_valid_q <= (state_next != ST_EMPTY);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (accept) state_next = ST_ONE;
      ST_ONE: begin
        if (accept && !pop) state_next = ST_FULL;
        else if (pop && !accept) state_next = ST_EMPTY;
      end
      ST_FULL:  if (pop) state_next = ST_ONE;
      default:  state_next = ST_EMPTY;
    endcase
    if (bus.flush) state_next = ST_EMPTY;
  end

  // Misaligned accesses keep their pc/en/br_flag so the exception can be attributed, everything else dies.
  always_comb begin
    capture = '{pc: bus.ex_pc, en: bus.ex_en, br_flag: bus.ex_br_flag,
                ctrl_op: bus.ex_ctrl_op, dst_addr: bus.ex_dst_addr, gpr_we_: bus.ex_gpr_we_,
                exp_code: bus.ex_exp_code, out: bus.ex_out};
    if (bus.miss_align) begin
      capture.ctrl_op  = CTRL_W'(CTRL_OP_NOP);
      capture.dst_addr = '0;
      capture.gpr_we_  = 1'b1;
      capture.exp_code = EXP_W'(ISA_EXP_MISS_ALIGN);
      capture.out      = '0;
    end
  end

  always_comb begin
    head_load  = 1'b0;
    head_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    head_d     = (state == ST_FULL) ? skid_q : capture;
    if (bus.flush) begin
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: head_load = accept;
        ST_ONE: begin
          if (accept && pop) head_load = 1'b1;
          else if (accept) skid_load = 1'b1;
          else if (pop) head_clear = 1'b1;
        end
        ST_FULL: begin
          head_load  = pop;
          skid_clear = pop;
        end
        default: begin
          head_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  mem_pipe_entry_reg #(.WIDTH(ENTRY_W), .CLEAR_VALUE(BUBBLE)) u_head (
    .clk   (clk),
    .reset (reset),
    .load  (head_load),
    .clear (head_clear),
    .d     (head_d),
    .q     (head_q)
  );

  mem_pipe_entry_reg #(.WIDTH(ENTRY_W), .CLEAR_VALUE(BUBBLE)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (capture),
    .q     (skid_q)
  );

  assign bus.up_ready     = up_ready_q;
  assign bus.dn_valid     = dn_valid_q;
  assign bus.mem_pc       = head_q.pc;
  assign bus.mem_en       = head_q.en;
  assign bus.mem_br_flag  = head_q.br_flag;
  assign bus.mem_ctrl_op  = head_q.ctrl_op;
  assign bus.mem_dst_addr = head_q.dst_addr;
  assign bus.mem_gpr_we_  = head_q.gpr_we_;
  assign bus.mem_exp_code = head_q.exp_code;
  assign bus.mem_out      = head_q.out;

endmodule

// File: tb/tb_mem_pipe_buf.sv
// Scoreboard bench for mem_pipe_buf: stimulus pushes expected entries, a negedge monitor checks the head.
module tb_mem_pipe_buf;

  typedef struct packed {
    logic [29:0] pc;
    logic        en;
    logic        br_flag;
    logic [1:0]  ctrl_op;
    logic [4:0]  dst_addr;
    logic        gpr_we_;
    logic [2:0]  exp_code;
    logic [31:0] out;
  } exp_t;

  localparam exp_t BUBBLE = '{pc: 30'h0, en: 1'b0, br_flag: 1'b0, ctrl_op: 2'd0,
                              dst_addr: 5'd0, gpr_we_: 1'b1, exp_code: 3'h0, out: 32'h0};

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   model_cnt;
  exp_t exp_q[$];

  mem_pipe_buf_if #(.PC_W(30), .DATA_W(32), .REG_ADDR_W(5), .CTRL_W(2), .EXP_W(3)) bus ();

  mem_pipe_buf #(.PC_W(30), .DATA_W(32), .REG_ADDR_W(5), .CTRL_W(2), .EXP_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t expected_entry(input logic [29:0] pc, input logic br,
                                          input logic [1:0] ctrl, input logic [4:0] dst,
                                          input logic we_n, input logic [2:0] ec,
                                          input logic [31:0] data, input logic ma);
    exp_t e;
    e = '{pc: pc, en: 1'b1, br_flag: br, ctrl_op: ctrl, dst_addr: dst,
          gpr_we_: we_n, exp_code: ec, out: data};
    if (ma) begin
      e.ctrl_op  = 2'd0;
      e.dst_addr = 5'd0;
      e.gpr_we_  = 1'b1;
      e.exp_code = 3'h4;
      e.out      = 32'h0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  // One clock of stimulus; the occupancy model decides acceptance and the expected entry is queued.
  task automatic applyStimulus(input logic v, input logic [29:0] pc, input logic [1:0] ctrl,
                               input logic [4:0] dst, input logic we_n, input logic [2:0] ec,
                               input logic [31:0] data, input logic ma, input logic fl,
                               input logic dr);
    bit acc;
    bit pop;
    bus.up_valid    = v;
    bus.ex_pc       = pc;
    bus.ex_en       = 1'b1;
    bus.ex_br_flag  = pc[0];
    bus.ex_ctrl_op  = ctrl;
    bus.ex_dst_addr = dst;
    bus.ex_gpr_we_  = we_n;
    bus.ex_exp_code = ec;
    bus.ex_out      = data;
    bus.miss_align  = ma;
    bus.flush       = fl;
    bus.dn_ready    = dr;
    checkOutput("up_ready", 64'(bus.up_ready), 64'(model_cnt != 2));
    checkOutput("dn_valid", 64'(bus.dn_valid), 64'(model_cnt != 0));
    acc = v && (model_cnt != 2);
    pop = (model_cnt != 0) && dr;
    if (acc && !fl) exp_q.push_back(expected_entry(pc, pc[0], ctrl, dst, we_n, ec, data, ma));
    @(posedge clk);
    #1;
    if (fl) begin
      model_cnt = 0;
      exp_q.delete();
    end else begin
      model_cnt = model_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
    end
  endtask

  task automatic push(input logic [31:0] data, input logic dr);
    applyStimulus(1'b1, 30'(data) + 30'h100, data[1:0], data[4:0], data[0], 3'h0, data,
                  1'b0, 1'b0, dr);
  endtask

  task automatic idle(input logic dr);
    applyStimulus(1'b0, 30'h0, 2'd0, 5'd0, 1'b1, 3'h0, 32'h0, 1'b0, 1'b0, dr);
  endtask

  // Monitor: a live head must match the oldest expected entry; a dead head must be a bubble.
  always @(negedge clk) begin
    exp_t act;
    act = '{pc: bus.mem_pc, en: bus.mem_en, br_flag: bus.mem_br_flag, ctrl_op: bus.mem_ctrl_op,
            dst_addr: bus.mem_dst_addr, gpr_we_: bus.mem_gpr_we_, exp_code: bus.mem_exp_code,
            out: bus.mem_out};
    n_checks++;
    if (bus.dn_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL spurious_dn_valid: got dn_valid=1 out=0x%0h, expected no live entry at %0t",
                 act.out, $time);
      end else begin
        if (act !== exp_q[0]) begin
          n_fail++;
          $display("[TB] FAIL head_entry: got 0x%0h, expected 0x%0h at %0t", act, exp_q[0], $time);
        end
        if (bus.dn_ready) void'(exp_q.pop_front());
      end
    end else if (act !== BUBBLE) begin
      n_fail++;
      $display("[TB] FAIL idle_bubble: got 0x%0h, expected 0x%0h at %0t", act, BUBBLE, $time);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    model_cnt       = 0;
    reset           = 1'b1;
    bus.up_valid    = 1'b0;
    bus.ex_pc       = '0;
    bus.ex_en       = 1'b0;
    bus.ex_br_flag  = 1'b0;
    bus.ex_ctrl_op  = '0;
    bus.ex_dst_addr = '0;
    bus.ex_gpr_we_  = 1'b1;
    bus.ex_exp_code = '0;
    bus.ex_out      = '0;
    bus.miss_align  = 1'b0;
    bus.flush       = 1'b0;
    bus.dn_ready    = 1'b0;
    #2;
    checkOutput("rst_dn_valid", 64'(bus.dn_valid), 64'd0);
    checkOutput("rst_up_ready", 64'(bus.up_ready), 64'd1);
    checkOutput("rst_gpr_we_", 64'(bus.mem_gpr_we_), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] streaming");
    for (int i = 1; i <= 8; i++) push(32'(i), 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("[TB] backpressure");
    push(32'hA, 1'b0);
    push(32'hB, 1'b0);
    push(32'hC, 1'b0);
    push(32'hC, 1'b0);
    push(32'hC, 1'b1);
    push(32'hC, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("[TB] misalign and field passthrough");
    applyStimulus(1'b1, 30'h100, 2'd2, 5'd7, 1'b0, 3'h0, 32'hDEAD, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 30'h2A5, 2'd1, 5'd19, 1'b0, 3'h2, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 30'h303, 2'd3, 5'd9, 1'b0, 3'h0, 32'hBEEF, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("[TB] flush in FULL with accept");
    push(32'hA0, 1'b0);
    push(32'hA1, 1'b0);
    applyStimulus(1'b1, 30'h77, 2'd1, 5'd3, 1'b0, 3'h0, 32'h77, 1'b0, 1'b1, 1'b0);
    push(32'h55, 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("[TB] flush in ONE with accept");
    push(32'h60, 1'b0);
    applyStimulus(1'b1, 30'h66, 2'd2, 5'd6, 1'b0, 3'h0, 32'h66, 1'b0, 1'b1, 1'b0);
    idle(1'b1);

    $display("[TB] flush with pop");
    push(32'h90, 1'b0);
    push(32'h91, 1'b0);
    applyStimulus(1'b0, 30'h0, 2'd0, 5'd0, 1'b1, 3'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("[TB] reset mid-stream in FULL");
    push(32'hE0, 1'b0);
    push(32'hE1, 1'b0);
    bus.up_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_dn_valid", 64'(bus.dn_valid), 64'd0);
    checkOutput("midrst_up_ready", 64'(bus.up_ready), 64'd1);
    checkOutput("midrst_gpr_we_", 64'(bus.mem_gpr_we_), 64'd1);
    checkOutput("midrst_exp_code", 64'(bus.mem_exp_code), 64'd0);
    checkOutput("midrst_out", 64'(bus.mem_out), 64'd0);
    model_cnt = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    push(32'h42, 1'b1);
    idle(1'b1);
    idle(1'b1);

    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
